// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator. One shared period counter, per-channel compare pairs and modes.
// Configuration is double-buffered. Define PWM_POLARITY_EN to add per-channel output polarity (pol).
module pwm_gen_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [WIDTH-1:0]          cfg_period,
  input  logic [2*CHANNELS-1:0]     cfg_func,
  input  logic [WIDTH*CHANNELS-1:0] cfg_cmp1,
  input  logic [WIDTH*CHANNELS-1:0] cfg_cmp2,
  input  logic                      cfg_commit,
`ifdef PWM_POLARITY_EN
  input  logic [CHANNELS-1:0]       pol,
`endif
  output logic                      commit_pending,
  output logic [WIDTH-1:0]          count_val,
  output logic                      period_end,
  output logic [CHANNELS-1:0]       pwm_out
);

  logic [WIDTH-1:0]                count_q, count_d;
  logic [WIDTH-1:0]                period_act_q, period_act_d;
  logic [CHANNELS-1:0][1:0]        func_act_q, func_act_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  cmp1_act_q, cmp1_act_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  cmp2_act_q, cmp2_act_d;
  logic                            commit_pending_q, commit_pending_d;
  logic [CHANNELS-1:0]             pwm_q, pwm_d;
  logic [CHANNELS-1:0]             func_hit;
  logic [CHANNELS-1:0]             idle_level;

  logic period_ok;
  logic wrap;
  logic load_cfg;

  // period_act-1 is only meaningful when period_ok, so the subtraction never underflows in use.
  assign period_ok = (period_act_q >= WIDTH'(2));
  assign wrap      = en & period_ok & (count_q == (period_act_q - WIDTH'(1)));
  assign load_cfg  = ~en | (wrap & (commit_pending_q | cfg_commit));

`ifdef PWM_POLARITY_EN
  logic [CHANNELS-1:0] pol_act_q, pol_act_d;

  always_comb begin
    pol_act_d = pol_act_q;
    if (load_cfg) begin
      pol_act_d = pol;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pol_act_q <= '0;
    end else begin
      pol_act_q <= pol_act_d;
    end
  end

  assign idle_level = pol_act_q;
`else
  assign idle_level = '0;
`endif

  always_comb begin
    count_d = count_q;
    if (!en || !period_ok || wrap) begin
      count_d = '0;
    end else begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_comb begin
    commit_pending_d = commit_pending_q;
    if (!en || wrap) begin
      commit_pending_d = 1'b0;
    end else if (cfg_commit) begin
      commit_pending_d = 1'b1;
    end
  end

  always_comb begin
    period_act_d = period_act_q;
    if (load_cfg) begin
      period_act_d = cfg_period;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      always_comb begin
        func_act_d[gi] = func_act_q[gi];
        cmp1_act_d[gi] = cmp1_act_q[gi];
        cmp2_act_d[gi] = cmp2_act_q[gi];
        if (load_cfg) begin
          func_act_d[gi] = cfg_func[2*gi +: 2];
          cmp1_act_d[gi] = cfg_cmp1[gi*WIDTH +: WIDTH];
          cmp2_act_d[gi] = cfg_cmp2[gi*WIDTH +: WIDTH];
        end
      end

      // Levels at the cmp1 extremes fall out of the plain compares since count < period.
      always_comb begin
        func_hit[gi] = 1'b0;
        case (func_act_q[gi])
          2'b00:   func_hit[gi] = (count_q < cmp1_act_q[gi]);
          2'b01:   func_hit[gi] = (count_q >= cmp1_act_q[gi]);
          2'b10:   func_hit[gi] = (count_q >= cmp1_act_q[gi]) && (count_q < cmp2_act_q[gi]);
          default: func_hit[gi] = 1'b0;
        endcase
      end

      always_comb begin
        pwm_d[gi] = idle_level[gi] ^ (en & ch_en[gi] & period_ok & func_hit[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q          <= '0;
      period_act_q     <= '0;
      func_act_q       <= '0;
      cmp1_act_q       <= '0;
      cmp2_act_q       <= '0;
      commit_pending_q <= 1'b0;
      pwm_q            <= '0;
    end else begin
      count_q          <= count_d;
      period_act_q     <= period_act_d;
      func_act_q       <= func_act_d;
      cmp1_act_q       <= cmp1_act_d;
      cmp2_act_q       <= cmp2_act_d;
      commit_pending_q <= commit_pending_d;
      pwm_q            <= pwm_d;
    end
  end

  assign commit_pending = commit_pending_q;
  assign count_val      = count_q;
  assign period_end     = wrap;
  assign pwm_out        = pwm_q;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Testbench for pwm_gen_multi: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a behavioural model.
module tb_pwm_gen_multi;
  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   ch_en = '0;
  logic [W-1:0]   cfg_period = '0;
  logic [2*N-1:0] cfg_func = '0;
  logic [W*N-1:0] cfg_cmp1 = '0;
  logic [W*N-1:0] cfg_cmp2 = '0;
  logic           cfg_commit = 1'b0;
  logic [N-1:0]   pol = '0;
  logic           commit_pending;
  logic [W-1:0]   count_val;
  logic           period_end;
  logic [N-1:0]   pwm_out;

  pwm_gen_multi #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .cfg_period(cfg_period),
    .cfg_func(cfg_func), .cfg_cmp1(cfg_cmp1), .cfg_cmp2(cfg_cmp2), .cfg_commit(cfg_commit),
`ifdef PWM_POLARITY_EN
    .pol(pol),
`endif
    .commit_pending(commit_pending), .count_val(count_val),
    .period_end(period_end), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: active configuration, counter position, pending flag, expected outputs.
  int           m_cnt, m_per;
  int           m_func [N];
  int           m_c1 [N];
  int           m_c2 [N];
  bit           m_pend;
  logic [N-1:0] m_pwm;
  logic [N-1:0] m_pol;

  function automatic bit fhit(input int f, input int c, input int a, input int b);
    case (f)
      0: return c < a;
      1: return c >= a;
      2: return (c >= a) && (c < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_load();
    m_per = cfg_period;
    for (int i = 0; i < N; i++) begin
      m_func[i] = cfg_func[2*i +: 2];
      m_c1[i]   = cfg_cmp1[i*W +: W];
      m_c2[i]   = cfg_cmp2[i*W +: W];
    end
`ifdef PWM_POLARITY_EN
    m_pol = pol;
`else
    m_pol = '0;
`endif
  endtask

  task automatic model_reset();
    m_cnt = 0; m_per = 0; m_pend = 0; m_pwm = '0; m_pol = '0;
    for (int i = 0; i < N; i++) begin
      m_func[i] = 0; m_c1[i] = 0; m_c2[i] = 0;
    end
  endtask

  task automatic model_update();
    bit           wrap;
    logic [N-1:0] np;
    if (!en) begin
      np = m_pol;
      model_load();
      m_cnt  = 0;
      m_pend = 0;
    end else begin
      wrap = (m_per >= 2) && (m_cnt == m_per - 1);
      for (int i = 0; i < N; i++)
        np[i] = m_pol[i] ^ (ch_en[i] && (m_per >= 2) && fhit(m_func[i], m_cnt, m_c1[i], m_c2[i]));
      m_cnt = (m_per < 2 || wrap) ? 0 : m_cnt + 1;
      if (wrap) begin
        if (m_pend || cfg_commit) model_load();
        m_pend = 0;
      end else if (cfg_commit) begin
        m_pend = 1;
      end
    end
    m_pwm = np;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_update();
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("count_val", int'(count_val), m_cnt);
      check("period_end", int'(period_end), int'(en && m_per >= 2 && m_cnt == m_per - 1));
      check("commit_pending", int'(commit_pending), int'(m_pend));
      check("pwm_out", int'(pwm_out), int'(m_pwm));
    end
  end

  // Inputs change just after each falling edge, once the compare process has sampled.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_count(input int v);
    int n = 0;
    while (int'(count_val) != v && n < 50) begin
      step();
      n++;
    end
    check("wait_count", int'(count_val), v);
  endtask

  task automatic set_ch(input int i, input int f, input int a, input int b);
    cfg_func[2*i +: 2] = 2'(f);
    cfg_cmp1[i*W +: W] = W'(a);
    cfg_cmp2[i*W +: W] = W'(b);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_count", int'(count_val), 0);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_pending", int'(commit_pending), 0);
    check("rst_period_end", int'(period_end), 0);
    @(negedge clk); #1 rst = 1'b0;

    // Basic modes at period 10
    cfg_period = 10; ch_en = 4'hF;
    set_ch(0, 0, 3, 0); set_ch(1, 1, 7, 0); set_ch(2, 2, 2, 5); set_ch(3, 2, 5, 5);
    step();
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("lit_count", int'(count_val), k % 10);
      check("lit_pe", int'(period_end), int'(k % 10 == 9));
      check("lit_ch0", int'(pwm_out[0]), int'((k - 1) % 10 < 3));
      check("lit_ch1", int'(pwm_out[1]), int'((k - 1) % 10 >= 7));
      check("lit_ch2", int'(pwm_out[2]), int'((k - 1) % 10 >= 2 && (k - 1) % 10 < 5));
      check("lit_ch3", int'(pwm_out[3]), 0);
    end

    // Commit mid-period waits for the wrap
    wait_count(4);
    set_ch(0, 0, 8, 0); cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    while (int'(count_val) != 9 && int'(count_val) != 0) begin
      check("lit_pending_hi", int'(commit_pending), 1);
      check("lit_old_duty", int'(pwm_out[0]), int'(int'(count_val) - 1 < 3));
      step();
    end
    check("lit_pending_at9", int'(commit_pending), 1);
    step();
    check("lit_pending_clr", int'(commit_pending), 0);
    wait_count(8);
    check("lit_new_duty_hi", int'(pwm_out[0]), 1);
    step();
    check("lit_new_duty_lo", int'(pwm_out[0]), 0);

    // Commit strobed in the wrap cycle itself
    set_ch(0, 0, 3, 0); cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    check("lit_wrap_commit_pend", int'(commit_pending), 0);
    check("lit_wrap_commit_cnt", int'(count_val), 0);
    step(); step(); step(); step();
    check("lit_wrap_commit_duty", int'(pwm_out[0]), 0);

    // Drop en mid-period
    wait_count(5);
    en = 1'b0;
    step();
    check("lit_endrop_cnt", int'(count_val), 0);
    check("lit_endrop_pwm", int'(pwm_out), 0);

    // cmp1 extremes for left/right alignment
    set_ch(0, 0, 0, 0); set_ch(1, 1, 0, 0); set_ch(2, 0, 10, 0); set_ch(3, 1, 10, 0);
    step();
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("lit_edge_pwm", int'(pwm_out), 6);
    end

    // Degenerate periods 1 and 0
    for (int p = 1; p >= 0; p--) begin
      en = 1'b0; cfg_period = W'(p); set_ch(0, 0, 3, 0); set_ch(1, 1, 0, 0);
      step();
      en = 1'b1;
      for (int k = 0; k < 5; k++) begin
        step();
        check("lit_degen_cnt", int'(count_val), 0);
        check("lit_degen_pe", int'(period_end), 0);
        check("lit_degen_pwm", int'(pwm_out), 0);
      end
    end

    // Asynchronous reset with a commit pending and outputs active
    en = 1'b0; cfg_period = 10;
    set_ch(0, 0, 8, 0); set_ch(1, 1, 0, 0); set_ch(2, 2, 2, 9); set_ch(3, 1, 3, 0);
    step();
    en = 1'b1;
    wait_count(4);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    check("lit_pre_rst_pwm", int'(pwm_out), 4'b1111);
    check("lit_pre_rst_pend", int'(commit_pending), 1);
    rst = 1'b1;
    #1;
    check("lit_rst_cnt", int'(count_val), 0);
    check("lit_rst_pwm", int'(pwm_out), 0);
    check("lit_rst_pend", int'(commit_pending), 0);
    step();
    rst = 1'b0;

    // Randomized operation
    for (int n = 0; n < 3000; n++) begin
      en         = ($urandom_range(0, 19) != 0);
      cfg_commit = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) ch_en = N'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        cfg_period = W'($urandom_range(0, 14));
        for (int i = 0; i < N; i++)
          set_ch(i, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
        pol = N'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
